// File: rtl/d_sram_like_ctrl_pkg.sv
// Shared types for the M-stage sram-like data-access controller.
package d_sram_like_ctrl_pkg;
   typedef enum logic [1:0] {SZ_BYTE = 2'd0, SZ_HALF = 2'd1, SZ_WORD = 2'd2} size_e;
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;
endpackage

// File: rtl/d_sram_like_ctrl_if.sv
// sram-like data bus: req/addr_ok address phase, data_ok data phase.
interface d_sram_like_ctrl_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              data_req;
   logic              data_wr;
   logic [1:0]        data_size;
   logic [ADDR_W-1:0] data_addr;
   logic [DATA_W-1:0] data_wdata;
   logic              data_addr_ok;
   logic              data_data_ok;
   logic [DATA_W-1:0] data_rdata;

   modport master (
      output data_req, data_wr, data_size, data_addr, data_wdata,
      input  data_addr_ok, data_data_ok, data_rdata
   );
   modport slave (
      input  data_req, data_wr, data_size, data_addr, data_wdata,
      output data_addr_ok, data_data_ok, data_rdata
   );
endinterface

// File: rtl/d_sram_like_ctrl.sv
// Turns one M-stage load/store into exactly one sram-like bus transaction and
// stalls the pipeline until the data phase completes.
module d_sram_like_ctrl
   import d_sram_like_ctrl_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_en_i,
   input  logic              mem_wr_i,
   input  logic [3:0]        sel_i,
   input  logic [1:0]        size_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              except_i,
   input  logic              stall_i,
   d_sram_like_ctrl_if.master bus,
   output logic [DATA_W-1:0] rdata_o,
   output logic              stallreq_o
);

   state_e            state_q, state_d;
   logic              wr_q, wr_d;
   logic [1:0]        size_q, size_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              go;

   // Faulting instructions and stores with no active lane never reach the bus.
   assign go = mem_en_i & ~except_i & ~(mem_wr_i & ~|sel_i);

   always_comb begin
      state_d        = state_q;
      wr_d           = wr_q;
      size_d         = size_q;
      addr_d         = addr_q;
      wdata_d        = wdata_q;
      rdata_d        = rdata_q;
      bus.data_req   = 1'b0;
      bus.data_wr    = wr_q;
      bus.data_size  = size_q;
      bus.data_addr  = addr_q;
      bus.data_wdata = wdata_q;
      rdata_o        = rdata_q;
      stallreq_o     = 1'b0;
      case (state_q)
         S_IDLE: begin
            bus.data_req   = go;
            bus.data_wr    = mem_wr_i;
            bus.data_size  = size_i;
            bus.data_addr  = addr_i;
            bus.data_wdata = wdata_i;
            stallreq_o     = go;
            if (go) begin
               wr_d    = mem_wr_i;
               size_d  = size_i;
               addr_d  = addr_i;
               wdata_d = wdata_i;
               state_d = bus.data_addr_ok ? S_WAIT : S_REQ;
            end
         end
         S_REQ: begin
            bus.data_req = 1'b1;
            stallreq_o   = 1'b1;
            if (bus.data_addr_ok) state_d = S_WAIT;
         end
         S_WAIT: begin
            // data_ok cycle releases the pipeline with the load data bypassed.
            if (bus.data_data_ok) begin
               rdata_d = bus.data_rdata;
               rdata_o = bus.data_rdata;
               state_d = stall_i ? S_DONE : S_IDLE;
            end else begin
               stallreq_o = 1'b1;
            end
         end
         S_DONE: begin
            // Held by another stall source: the access is finished, do not re-issue.
            if (!stall_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         wr_q    <= 1'b0;
         size_q  <= 2'd0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         wr_q    <= wr_d;
         size_q  <= size_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

endmodule

// File: tb/tb_d_sram_like_ctrl.sv
// Scoreboarded bench: expected bus transactions queued at issue, checked at handshake.
module tb_d_sram_like_ctrl;
   import d_sram_like_ctrl_pkg::*;

   typedef struct {
      logic        wr;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
   } txn_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_en_i = 1'b0, mem_wr_i = 1'b0, except_i = 1'b0, stall_i = 1'b0;
   logic [3:0]  sel_i = 4'h0;
   logic [1:0]  size_i = 2'd0;
   logic [31:0] addr_i = '0, wdata_i = '0;
   logic [31:0] rdata_o;
   logic        stallreq_o;

   always #5 clk = ~clk;

   d_sram_like_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   d_sram_like_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst), .mem_en_i(mem_en_i), .mem_wr_i(mem_wr_i), .sel_i(sel_i),
      .size_i(size_i), .addr_i(addr_i), .wdata_i(wdata_i), .except_i(except_i),
      .stall_i(stall_i), .bus(bus), .rdata_o(rdata_o), .stallreq_o(stallreq_o)
   );

   int errs = 0, checks = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h want %h", tag, act, exp);
      end
   endtask

   // Slave: addr_ok after addr_dly req cycles, data_ok data_dly cycles after accept.
   int          addr_dly = 0, data_dly = 0, req_cnt = 0, d_cnt = 0;
   logic        pend = 1'b0;
   logic [31:0] slave_rdata = '0;

   assign bus.data_addr_ok = bus.data_req && (req_cnt >= addr_dly);
   assign bus.data_data_ok = pend && (d_cnt >= data_dly);
   assign bus.data_rdata   = bus.data_data_ok ? slave_rdata : 32'hBAD0_BAD0;

   always @(posedge clk) begin
      if (rst) begin
         req_cnt <= 0;
         d_cnt   <= 0;
         pend    <= 1'b0;
      end else begin
         if (bus.data_req && bus.data_addr_ok) begin
            req_cnt <= 0;
            pend    <= 1'b1;
            d_cnt   <= 0;
         end else if (bus.data_req) begin
            req_cnt <= req_cnt + 1;
         end
         if (bus.data_data_ok) pend <= 1'b0;
         else if (pend)        d_cnt <= d_cnt + 1;
      end
   end

   // Scoreboard monitor
   txn_t exp_q[$];
   txn_t cur;
   logic have_cur = 1'b0;
   int   req_cyc = 0, req_hs = 0;

   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            have_cur = 1'b0;
         end else begin
            if (bus.data_req === 1'b1) begin
               req_cyc++;
               chk("no_overlap", {31'd0, pend}, 32'd0);
               if (exp_q.size() == 0) begin
                  chk("unexpected_req", 32'd1, 32'd0);
               end else begin
                  chk("bus_wr",    {31'd0, bus.data_wr}, {31'd0, exp_q[0].wr});
                  chk("bus_size",  {30'd0, bus.data_size}, {30'd0, exp_q[0].size});
                  chk("bus_addr",  bus.data_addr, exp_q[0].addr);
                  chk("bus_wdata", bus.data_wdata, exp_q[0].wdata);
                  if (bus.data_addr_ok) begin
                     cur      = exp_q.pop_front();
                     have_cur = 1'b1;
                     req_hs++;
                  end
               end
            end
            if (bus.data_data_ok && have_cur) begin
               if (!cur.wr) chk("rdata_o_bypass", rdata_o, cur.rdata);
               chk("release_on_data_ok", {31'd0, stallreq_o}, 32'd0);
               have_cur = 1'b0;
            end
         end
      end
   end

   // Drive one instruction, wait for release; leaves inputs applied, returns just after the retiring edge.
   task automatic issue(input logic wr, input logic [3:0] sel, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                        input logic exc, input int adly, input int ddly, output int scyc);
      logic done;
      mem_en_i = 1'b1; mem_wr_i = wr; sel_i = sel; size_i = sz;
      addr_i = a; wdata_i = wd; except_i = exc;
      addr_dly = adly; data_dly = ddly; slave_rdata = rd;
      if (!exc && !(wr && sel == 4'h0)) exp_q.push_back('{wr, sz, a, wd, rd});
      scyc = 0;
      done = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!stallreq_o) begin
            done = 1'b1;
            break;
         end
         scyc++;
         @(posedge clk); #1;
         // Inputs are no longer trusted once issued; bus must use the held copy.
         addr_i = ~a; wdata_i = ~wd; except_i = 1'b1;
      end
      if (!done) chk("release_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic go_idle();
      mem_en_i = 1'b0; except_i = 1'b0; mem_wr_i = 1'b0; sel_i = 4'h0;
   endtask

   int sc, h0, c0;

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_req",      {31'd0, bus.data_req}, 32'd0);
      chk("rst_stallreq", {31'd0, stallreq_o}, 32'd0);
      chk("rst_rdata",    rdata_o, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Load word, addr_ok immediately, data_ok next cycle
      h0 = req_hs; c0 = req_cyc;
      issue(1'b0, 4'hF, SZ_WORD, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, 0, 0, sc);
      chk("t1_stall_cycles", sc, 1);
      chk("t1_req_cycles", req_cyc - c0, 1);
      go_idle();
      @(negedge clk);
      chk("t1_idle", {30'd0, dut.state_q}, {30'd0, S_IDLE});
      chk("t1_rdata_hold", rdata_o, 32'hDEAD_BEEF);
      @(posedge clk); #1;

      // Store byte, addr_ok delayed 3 cycles
      c0 = req_cyc;
      issue(1'b1, 4'b0001, SZ_BYTE, 32'h8000_0021, 32'h0000_00AB, 32'h0, 1'b0, 3, 0, sc);
      chk("t2_stall_cycles", sc, 4);
      chk("t2_req_cycles", req_cyc - c0, 4);
      go_idle();
      @(posedge clk); #1;

      // Faulting load and zero-lane store: no bus activity, no stall
      h0 = req_hs; c0 = req_cyc;
      issue(1'b0, 4'hF, SZ_WORD, 32'h8000_0031, 32'h0, 32'h0, 1'b1, 0, 0, sc);
      chk("t3_exc_stall", sc, 0);
      issue(1'b1, 4'h0, SZ_BYTE, 32'h8000_0040, 32'h55, 32'h0, 1'b0, 0, 0, sc);
      chk("t3_nosel_stall", sc, 0);
      chk("t3_req_cycles", req_cyc - c0, 0);
      chk("t3_handshakes", req_hs - h0, 0);
      go_idle();
      @(posedge clk); #1;

      // data_ok under an external stall: DONE, no re-issue, data held
      h0 = req_hs;
      stall_i = 1'b1;
      issue(1'b0, 4'hF, SZ_WORD, 32'h1000_0040, 32'h0, 32'h1234_5678, 1'b0, 1, 2, sc);
      chk("t4_stall_cycles", sc, 4);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t4_done_state", {30'd0, dut.state_q}, {30'd0, S_DONE});
         chk("t4_done_req",   {31'd0, bus.data_req}, 32'd0);
         chk("t4_done_stall", {31'd0, stallreq_o}, 32'd0);
         chk("t4_done_rdata", rdata_o, 32'h1234_5678);
         @(posedge clk); #1;
      end
      stall_i = 1'b0;
      @(negedge clk);
      chk("t4_done_req_last", {31'd0, bus.data_req}, 32'd0);
      @(posedge clk); #1;
      go_idle();
      @(negedge clk);
      chk("t4_idle", {30'd0, dut.state_q}, {30'd0, S_IDLE});
      chk("t4_one_req", req_hs - h0, 1);
      @(posedge clk); #1;

      // Reset while waiting for data
      mem_en_i = 1'b1; mem_wr_i = 1'b0; sel_i = 4'hF; size_i = SZ_WORD;
      addr_i = 32'h2000_0000; wdata_i = 32'h0; except_i = 1'b0;
      addr_dly = 0; data_dly = 5; slave_rdata = 32'h7777_7777;
      exp_q.push_back('{1'b0, SZ_WORD, 32'h2000_0000, 32'h0, 32'h7777_7777});
      @(posedge clk); #1;
      go_idle();
      @(negedge clk);
      chk("t5_in_wait", {30'd0, dut.state_q}, {30'd0, S_WAIT});
      chk("t5_wait_stall", {31'd0, stallreq_o}, 32'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("t5_idle", {30'd0, dut.state_q}, {30'd0, S_IDLE});
      chk("t5_req", {31'd0, bus.data_req}, 32'd0);
      chk("t5_stall", {31'd0, stallreq_o}, 32'd0);
      chk("t5_rdata", rdata_o, 32'd0);
      @(posedge clk); #1;

      // Back-to-back load then store
      h0 = req_hs;
      issue(1'b0, 4'hF, SZ_WORD, 32'h8000_0100, 32'h0, 32'hCAFE_0001, 1'b0, 0, 1, sc);
      chk("t6_load_stall", sc, 2);
      issue(1'b1, 4'b0011, SZ_HALF, 32'h8000_0104, 32'h0000_BEEF, 32'h0, 1'b0, 1, 0, sc);
      chk("t6_store_stall", sc, 2);
      chk("t6_two_reqs", req_hs - h0, 2);
      go_idle();
      @(posedge clk); #1;

      // A few random accesses
      for (int n = 0; n < 6; n++) begin
         logic        w;
         int          ad, dd;
         logic [31:0] a, d, r;
         w  = 1'($urandom_range(0, 1));
         ad = $urandom_range(0, 3);
         dd = $urandom_range(0, 3);
         a  = $urandom & 32'hFFFF_FFFC;
         d  = $urandom;
         r  = $urandom;
         issue(w, 4'hF, SZ_WORD, a, d, r, 1'b0, ad, dd, sc);
         chk("rnd_stall_cycles", sc, ad + 1 + dd);
      end
      go_idle();
      repeat (2) @(posedge clk);
      #1;
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
